trace_filter_multi_event: RTL
=============================

Name: trace_filter_multi_event

Overview:
- Runtime-configurable successor of the CMS instruction trace filter; sits between the CPU trace tap and the trace FIFO and asserts drop_instr for instructions not worth storing.
- Generalises trigger sources to NUM_EVENTS HPM counters with per-event enables.
- Adds a programmable run-length of trailing instructions, per-class enables, wrap-safe counter-change detection, per-instruction keep reasons and saturating kept/dropped statistics.

Parameters:
INSTR_WIDTH, 32, width of next_instr
COUNTER_WIDTH, 64, width of each monitored HPM counter
NUM_EVENTS, 2, number of monitored HPM counters (event 0 = trap, event 1 = interrupt by convention)
MAX_TRAILING, 4, maximum trailing instructions kept after a class trigger (>=1)
TRAIL_W, $clog2(MAX_TRAILING+1), width of trailing_count / internal run counter
STAT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc_valid  in  1  next_instr valid this cycle
next_instr  in  INSTR_WIDTH  retired instruction
event_counters  in  NUM_EVENTS*COUNTER_WIDTH  packed HPM counters, event i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
class_enable  in  4  [0] branch, [1] jump, [2] wfi, [3] pass-all
event_enable  in  NUM_EVENTS  per-event trigger enable
trailing_count  in  TRAIL_W  trailing run length; values >MAX_TRAILING clamp to MAX_TRAILING
drop_instr  out  1  1 = drop the last sampled instruction
keep_reason  out  NUM_EVENTS+5  [0] branch, [1] jump, [2] wfi, [3] trailing, [4] pass-all, [5+i] event i
kept_count  out  STAT_WIDTH  saturating count of kept instructions
dropped_count  out  STAT_WIDTH  saturating count of dropped instructions

Behaviour:
- Reset (rst=1 at clk edge):
  - drop_instr=1; keep_reason=0; kept_count=0; dropped_count=0.
  - Trailing run counter=0; all event-pending flags=0; primed=0.
- Latency: the instruction sampled with pc_valid=1 at edge t gets its drop_instr/keep_reason at t+1.
  - Outputs hold until the next pc_valid edge.
  - pc_valid=0 changes no classification state.
- Classification. A 32-bit instruction has instr[1:0]==2'b11; otherwise it is compressed and only [15:0] is decoded.
  - branch: 32-bit opcode 1100011; or C: [1:0]=01 and [15:14]=11.
  - jump: 32-bit opcode 1101111 or 1100111; or C: [1:0]=01 and [15:13] in {001,101}; or C: [1:0]=10, [15:13]=100, [6:2]=0, [11:7]!=0.
  - wfi: instr==32'h10500073.
  - Each class bit is ANDed with its class_enable bit.
- Trailing run:
  - When a sampled instruction has any enabled class bit, the run counter loads clamp(trailing_count).
  - Otherwise, if counter>0, the instruction is kept with reason[3] and the counter decrements.
  - A new class trigger during a run reloads the counter (no accumulation).
  - Reason[3] is never set together with a class bit on the same instruction.
- Events:
  - prev_counter[i] registers event_counters[i] every cycle.
  - Change detection uses current != prev, so counter wrap-around is detected.
  - Detection is inhibited on the first cycle after reset; primed becomes 1 thereafter.
  - A change seen at edge t sets pending[i] (if event_enable[i]) at t+1.
  - The first pc_valid instruction sampled while pending[i]=1 is kept with reason[5+i], and pending[i] clears.
  - A new change at the same edge that clears pending re-sets pending.
  - An instruction sampled in the same edge as the change is not tagged.
  - Clearing event_enable[i] clears pending[i].
- Pass-all: class_enable[3]=1 keeps every instruction with reason[4]; trailing and event state still update normally.
- drop_instr = ~|keep_reason, registered together with keep_reason.
- Statistics: on each pc_valid edge, exactly one of kept_count/dropped_count increments; each saturates at all-ones.
- Reset mid-run clears the run counter, pending flags and statistics; no instruction in flight survives.

Test Plan:
- Reset, then pc_valid with addi (32'h00100093), class_enable=4'b0111 -> cycle after sample: drop_instr=1, keep_reason=0, dropped_count=1.
- beq (32'h00208463) then 3x addi, trailing_count=2 -> keep_reason sequence 0x01, 0x08, 0x08, then drop; kept_count=3, dropped_count=1.
- c.jr ra (16'h8082) during trailing run, trailing_count=3 -> run counter reloads to 3; next 3 instructions tagged reason[3], 4th dropped; trailing_count=7 with MAX_TRAILING=4 -> exactly 4 trailing kept.
- event_counters[0] goes 5->6 with no pc_valid for 10 cycles, then addi -> that addi kept with reason bit 5; the following addi is dropped; event_enable[0]=0 -> no keep.
- event_counters[1] wraps from all-ones to 0 -> pending set, next instruction kept with reason bit 6; a nonzero counter value at reset release -> no spurious event.
- Force kept_count to all-ones-1 via a long pass-all run -> saturates at all-ones; asserting rst mid-trailing-run -> outputs back to reset values next cycle.

Source files
------------

// File: rtl/trace_filter_multi_event.sv
// Trace filter: flags retired instructions not worth storing, with class/trailing/event/pass-all keep reasons and stats.
// Latency: instruction sampled with pc_valid at edge t yields drop_instr/keep_reason at t+1; outputs hold between samples.
// Backpressure: none; pc_valid is the only qualifier and every sampled instruction is classified.
module trace_filter_multi_event #(
    parameter int INSTR_WIDTH   = 32,
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 2,
    parameter int MAX_TRAILING  = 4,
    parameter int TRAIL_W       = $clog2(MAX_TRAILING + 1),
    parameter int STAT_WIDTH    = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pc_valid,
    input  logic [INSTR_WIDTH-1:0]            next_instr,
    input  logic [NUM_EVENTS*COUNTER_WIDTH-1:0] event_counters,
    input  logic [3:0]                        class_enable,
    input  logic [NUM_EVENTS-1:0]             event_enable,
    input  logic [TRAIL_W-1:0]                trailing_count,
    output logic                              drop_instr,
    output logic [NUM_EVENTS+4:0]             keep_reason,
    output logic [STAT_WIDTH-1:0]             kept_count,
    output logic [STAT_WIDTH-1:0]             dropped_count
);

    localparam logic [TRAIL_W-1:0] MAX_T = TRAIL_W'(MAX_TRAILING);

    logic [31:0]                          instr;
    logic                                 is_rv32;
    logic                                 cls_branch;
    logic                                 cls_jump;
    logic                                 cls_wfi;
    logic [2:0]                           cls_hit;
    logic [TRAIL_W-1:0]                   trail_load;
    logic                                 trail_tag;
    logic [TRAIL_W-1:0]                   run_cnt;
    logic [TRAIL_W-1:0]                   run_d;
    logic [NUM_EVENTS-1:0]                pending;
    logic [NUM_EVENTS-1:0]                pending_d;
    logic [NUM_EVENTS-1:0]                ev_change;
    logic [NUM_EVENTS-1:0]                ev_tag;
    logic [NUM_EVENTS*COUNTER_WIDTH-1:0]  prev_counters;
    logic                                 primed;
    logic [NUM_EVENTS+4:0]                reason_d;

    assign instr = next_instr[31:0];

    // Decode the instruction into enabled branch/jump/wfi class hits and the clamped run length.
    always_comb begin
        is_rv32    = (instr[1:0] == 2'b11);
        cls_branch = 1'b0;
        cls_jump   = 1'b0;
        if (is_rv32) begin
            cls_branch = (instr[6:0] == 7'b1100011);
            cls_jump   = (instr[6:0] == 7'b1101111) || (instr[6:0] == 7'b1100111);
        end else begin
            cls_branch = (instr[1:0] == 2'b01) && (instr[15:14] == 2'b11);
            cls_jump   = ((instr[1:0] == 2'b01) &&
                          ((instr[15:13] == 3'b001) || (instr[15:13] == 3'b101))) ||
                         ((instr[1:0] == 2'b10) && (instr[15:13] == 3'b100) &&
                          (instr[6:2] == 5'd0) && (instr[11:7] != 5'd0));
        end
        cls_wfi    = (instr == 32'h1050_0073);
        cls_hit    = {cls_wfi, cls_jump, cls_branch} & class_enable[2:0];
        trail_load = (trailing_count > MAX_T) ? MAX_T : trailing_count;
    end

    // Trailing run: a class hit reloads the run, otherwise a live run tags and counts down.
    always_comb begin
        trail_tag = 1'b0;
        run_d     = run_cnt;
        if (pc_valid) begin
            if (cls_hit != 3'b000) begin
                run_d = trail_load;
            end else if (run_cnt != '0) begin
                trail_tag = 1'b1;
                run_d     = run_cnt - TRAIL_W'(1);
            end
        end
    end

    // Event change detection (wrap-safe inequality) and pending flag next-state.
    always_comb begin
        ev_change = '0;
        ev_tag    = '0;
        pending_d = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            ev_change[i] = primed &&
                (event_counters[i*COUNTER_WIDTH +: COUNTER_WIDTH] !=
                 prev_counters[i*COUNTER_WIDTH +: COUNTER_WIDTH]);
            ev_tag[i]    = pc_valid && pending[i] && event_enable[i];
            // A change on the consuming edge re-arms; a disabled event never stays pending.
            pending_d[i] = event_enable[i] &&
                           (ev_change[i] || (pending[i] && !pc_valid));
        end
        reason_d = {ev_tag, class_enable[3], trail_tag, cls_hit};
    end

    // Previous counter snapshot tracks the inputs every cycle, reset or not.
    always_ff @(posedge clk) begin
        prev_counters <= event_counters;
    end

    // Filter state, registered outputs and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_instr    <= 1'b1;
            keep_reason   <= '0;
            kept_count    <= '0;
            dropped_count <= '0;
            run_cnt       <= '0;
            pending       <= '0;
            primed        <= 1'b0;
        end else begin
            primed  <= 1'b1;
            pending <= pending_d;
            run_cnt <= run_d;
            if (pc_valid) begin
                keep_reason <= reason_d;
                drop_instr  <= ~|reason_d;
                if (|reason_d) begin
                    if (kept_count != '1) begin
                        kept_count <= kept_count + STAT_WIDTH'(1);
                    end
                end else begin
                    if (dropped_count != '1) begin
                        dropped_count <= dropped_count + STAT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule
